// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps one imem request in
// flight, hands instructions to decode and squashes responses made stale by redirects.
module fetch_ctrl #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] pc,
  output logic            misaligned,
  output logic [2:0]      state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DROP = 3'd3,
    HOLD = 3'd4
  } state_t;

  state_t state;

  // Redirect targets are forced word aligned; the low bits only feed misaligned.
  logic [XLEN-1:0] target;
  assign target = {redirect_pc[XLEN-1:2], 2'b00};

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign state_dbg      = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      if (redirect && (redirect_pc[1:0] != 2'b00)) misaligned <= 1'b1;
      case (state)
        IDLE: begin
          if (redirect) pc <= target;
          state <= REQ;
        end
        REQ: begin
          // An accepted request under redirect still owes one response.
          if (redirect) begin
            pc <= target;
            if (imem_req_ready) state <= DROP;
          end else if (imem_req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            pc    <= target;
            state <= imem_rsp_valid ? REQ : DROP;
          end else if (imem_rsp_valid) begin
            instr       <= imem_rsp_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + XLEN'(4);
            state       <= HOLD;
          end
        end
        DROP: begin
          if (redirect) pc <= target;
          if (imem_rsp_valid) state <= REQ;
        end
        HOLD: begin
          if (redirect) begin
            pc          <= target;
            instr_valid <= 1'b0;
            state       <= REQ;
          end else if (!stall) begin
            instr_valid <= 1'b0;
            state       <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl: one table row per clock with
// hand-computed expected outputs, plus an asynchronous reset sequence.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc;
  logic        misaligned;
  logic [2:0]  state_dbg;

  int n_vec  = 0;
  int n_miss = 0;

  fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .pc(pc), .misaligned(misaligned), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        stall;
    logic        rdy;
    logic        rsp;
    logic [31:0] data;
    logic        e_rv;
    logic [31:0] e_pc;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic redir, input logic [31:0] rpc, input logic st,
                     input logic rdy, input logic rsp, input logic [31:0] data,
                     input logic erv, input logic [31:0] epc, input logic eiv,
                     input logic [31:0] ein, input logic [31:0] eipc, input logic emis);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.stall = st; v.rdy = rdy; v.rsp = rsp; v.data = data;
    v.e_rv = erv; v.e_pc = epc; v.e_iv = eiv; v.e_instr = ein; v.e_ipc = eipc; v.e_mis = emis;
    vecs.push_back(v);
  endtask

  // instr/instr_pc are only meaningful while instr_valid is expected high.
  task automatic check(input string name, input vec_t v);
    logic bad;
    n_vec++;
    bad = (imem_req_valid !== v.e_rv) || (imem_req_addr !== v.e_pc) || (pc !== v.e_pc) ||
          (instr_valid !== v.e_iv) || (misaligned !== v.e_mis) ||
          (v.e_iv && ((instr !== v.e_instr) || (instr_pc !== v.e_ipc)));
    if (bad) begin
      n_miss++;
      $display("FAIL %s: got rv=%0b addr=%h pc=%h iv=%0b instr=%h ipc=%h mis=%0b; want rv=%0b pc=%h iv=%0b instr=%h ipc=%h mis=%0b",
               name, imem_req_valid, imem_req_addr, pc, instr_valid, instr, instr_pc, misaligned,
               v.e_rv, v.e_pc, v.e_iv, v.e_instr, v.e_ipc, v.e_mis);
    end
  endtask

  task automatic check_reset(input string name);
    vec_t z;
    z = '{default: '0};
    n_vec++;
    if ((imem_req_valid !== 1'b0) || (imem_req_addr !== 32'h0) || (pc !== 32'h0) ||
        (instr_valid !== 1'b0) || (instr !== 32'h0) || (instr_pc !== 32'h0) ||
        (misaligned !== 1'b0)) begin
      n_miss++;
      $display("FAIL %s: got rv=%0b addr=%h pc=%h iv=%0b instr=%h ipc=%h mis=%0b; want all zero",
               name, imem_req_valid, imem_req_addr, pc, instr_valid, instr, instr_pc, misaligned);
    end
    if (z.e_rv !== 1'b0) n_miss++;
  endtask

  task automatic drive(input vec_t v);
    redirect = v.redir; redirect_pc = v.rpc; stall = v.stall;
    imem_req_ready = v.rdy; imem_rsp_valid = v.rsp; imem_rsp_data = v.data;
  endtask

  localparam logic [31:0] X = 32'h0;

  initial begin
    vec_t idle_v;
    vec_t post_v;
    // redir rpc stall rdy rsp data | rv pc iv instr ipc mis
    add(0, X, 0, 0, 0, X,             1, 32'h000, 0, X, X, 0);            // IDLE -> REQ
    add(0, X, 0, 1, 0, X,             0, 32'h000, 0, X, X, 0);            // accept
    add(0, X, 0, 0, 1, 32'hA000_0000, 0, 32'h004, 1, 32'hA000_0000, 32'h000, 0);
    add(0, X, 0, 0, 0, X,             1, 32'h004, 0, X, X, 0);
    add(0, X, 0, 1, 0, X,             0, 32'h004, 0, X, X, 0);
    add(0, X, 0, 0, 1, 32'hA000_0001, 0, 32'h008, 1, 32'hA000_0001, 32'h004, 0);
    add(0, X, 0, 0, 0, X,             1, 32'h008, 0, X, X, 0);
    add(0, X, 0, 1, 0, X,             0, 32'h008, 0, X, X, 0);
    add(0, X, 0, 0, 1, 32'hA000_0002, 0, 32'h00C, 1, 32'hA000_0002, 32'h008, 0);
    // five stall cycles in HOLD; a stray response there is ignored
    add(0, X, 1, 1, 0, X,             0, 32'h00C, 1, 32'hA000_0002, 32'h008, 0);
    add(0, X, 1, 1, 1, 32'hDEAD_BEEF, 0, 32'h00C, 1, 32'hA000_0002, 32'h008, 0);
    add(0, X, 1, 0, 0, X,             0, 32'h00C, 1, 32'hA000_0002, 32'h008, 0);
    add(0, X, 1, 0, 0, X,             0, 32'h00C, 1, 32'hA000_0002, 32'h008, 0);
    add(0, X, 1, 0, 0, X,             0, 32'h00C, 1, 32'hA000_0002, 32'h008, 0);
    add(0, X, 0, 0, 0, X,             1, 32'h00C, 0, X, X, 0);
    add(0, X, 0, 1, 0, X,             0, 32'h00C, 0, X, X, 0);
    // redirect in WAIT, stale response two cycles later
    add(1, 32'h100, 0, 0, 0, X,       0, 32'h100, 0, X, X, 0);
    add(0, X, 0, 0, 0, X,             0, 32'h100, 0, X, X, 0);
    add(0, X, 0, 0, 1, 32'hBAD0_0000, 1, 32'h100, 0, X, X, 0);
    add(0, X, 0, 1, 0, X,             0, 32'h100, 0, X, X, 0);
    add(0, X, 0, 0, 1, 32'hA000_0003, 0, 32'h104, 1, 32'hA000_0003, 32'h100, 0);
    add(0, X, 0, 0, 0, X,             1, 32'h104, 0, X, X, 0);
    // redirect with ready in REQ: one response owed and discarded
    add(1, 32'h200, 0, 1, 0, X,       0, 32'h200, 0, X, X, 0);
    add(0, X, 0, 0, 1, 32'hBAD0_0001, 1, 32'h200, 0, X, X, 0);
    add(0, X, 0, 1, 0, X,             0, 32'h200, 0, X, X, 0);
    add(0, X, 0, 0, 1, 32'hA000_0004, 0, 32'h204, 1, 32'hA000_0004, 32'h200, 0);
    // redirect in HOLD beats stall; misaligned target 0x102
    add(1, 32'h102, 1, 0, 0, X,       1, 32'h100, 0, X, X, 1);
    // redirect while REQ not accepted; then wrap at top of address space
    add(1, 32'hFFFF_FFFC, 0, 0, 0, X, 1, 32'hFFFF_FFFC, 0, X, X, 1);
    add(0, X, 0, 1, 0, X,             0, 32'hFFFF_FFFC, 0, X, X, 1);
    add(0, X, 0, 0, 1, 32'hA000_0005, 0, 32'h000, 1, 32'hA000_0005, 32'hFFFF_FFFC, 1);
    add(0, X, 0, 0, 0, X,             1, 32'h000, 0, X, X, 1);
    add(0, X, 0, 1, 0, X,             0, 32'h000, 0, X, X, 1);
    // redirect coinciding with the response in WAIT: straight back to REQ
    add(1, 32'h300, 0, 0, 1, 32'hBAD0_0002, 1, 32'h300, 0, X, X, 1);
    add(0, X, 0, 1, 0, X,             0, 32'h300, 0, X, X, 1);
    add(0, X, 0, 0, 1, 32'hA000_0006, 0, 32'h304, 1, 32'hA000_0006, 32'h300, 1);
    add(0, X, 0, 0, 0, X,             1, 32'h304, 0, X, X, 1);
    // second redirect while in DROP
    add(1, 32'h400, 0, 1, 0, X,       0, 32'h400, 0, X, X, 1);
    add(1, 32'h500, 0, 0, 0, X,       0, 32'h500, 0, X, X, 1);
    add(0, X, 0, 0, 1, 32'hBAD0_0003, 1, 32'h500, 0, X, X, 1);
    add(0, X, 0, 1, 0, X,             0, 32'h500, 0, X, X, 1);

    idle_v = '{default: '0};
    drive(idle_v);
    reset = 1'b1;
    #1;
    check_reset("reset_t0");
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_held");
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i]);
    end

    // asynchronous reset while in WAIT takes effect mid-cycle
    drive(idle_v);
    #2 reset = 1'b1;
    #1;
    check_reset("async_reset_wait");
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    post_v = '{default: '0};
    post_v.e_rv = 1'b1;
    check("post_reset_req", post_v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
